// File: rtl/out_port_receiver.sv
// Receive side of a switch output port: pulls DA/SA/LEN/payload/FCS bytes,
// checks the XOR checksum and destination address, and keeps statistics.
module out_port_receiver (
  input  logic        clock,
  input  logic        reset,
  input  logic        ready,
  input  logic [7:0]  data_out,
  output logic        read,
  input  logic        en,
  input  logic [7:0]  port_addr,
  output logic        pkt_valid,
  output logic [7:0]  pkt_da,
  output logic [7:0]  pkt_sa,
  output logic [7:0]  pkt_len,
  output logic        fcs_err,
  output logic        da_err,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RX, DONE} state_t;

  state_t      state, next_state;
  logic [1:0]  rst_sync;
  logic        rst_n;
  logic [8:0]  issued;
  logic [8:0]  received;
  logic [8:0]  target;
  logic        rd_pend;
  logic [7:0]  acc;
  logic [7:0]  da_q;
  logic [7:0]  sa_q;
  logic [7:0]  len_q;
  logic        fcs_hit;

  // Assertion reaches every flop at once; release takes two edges to propagate.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // The byte being captured this cycle is the FCS when its index is LEN+3.
  assign fcs_hit = (state == RX) && rd_pend && (received >= 9'd3) &&
                   (received == ({1'b0, len_q} + 9'd3));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    read       = 1'b0;
    case (state)
      IDLE: if (en && ready) next_state = RX;
      RX: begin
        read = ready && (issued < target);
        if (fcs_hit) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign pkt_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Bytes arrive one cycle after their request; target stays open until LEN is known.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      issued    <= 9'd0;
      received  <= 9'd0;
      target    <= 9'h1FF;
      rd_pend   <= 1'b0;
      acc       <= 8'h00;
      da_q      <= 8'h00;
      sa_q      <= 8'h00;
      len_q     <= 8'h00;
      pkt_da    <= 8'h00;
      pkt_sa    <= 8'h00;
      pkt_len   <= 8'h00;
      fcs_err   <= 1'b0;
      da_err    <= 1'b0;
      pkt_count <= 16'h0000;
      err_count <= 16'h0000;
    end else begin
      rd_pend <= read;
      case (state)
        IDLE: begin
          issued   <= 9'd0;
          received <= 9'd0;
          target   <= 9'h1FF;
          acc      <= 8'h00;
          rd_pend  <= 1'b0;
        end
        RX: begin
          if (read) issued <= issued + 9'd1;
          if (rd_pend) begin
            received <= received + 9'd1;
            case (received)
              9'd0: da_q <= data_out;
              9'd1: sa_q <= data_out;
              9'd2: begin
                len_q  <= data_out;
                target <= {1'b0, data_out} + 9'd4;
              end
              default: ;
            endcase
            if (fcs_hit) begin
              pkt_da  <= da_q;
              pkt_sa  <= sa_q;
              pkt_len <= len_q;
              fcs_err <= (acc != data_out);
              da_err  <= (da_q != port_addr);
            end else begin
              acc <= acc ^ data_out;
            end
          end
        end
        DONE: begin
          if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
          if ((fcs_err || da_err) && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_receiver.sv
// Bench for out_port_receiver: models the switch port byte queue and checks
// completed packets against a scoreboard of expected fields.
module tb_out_port_receiver;

  logic        clock = 1'b0;
  logic        reset;
  logic        ready;
  logic [7:0]  data_out;
  logic        read;
  logic        en;
  logic [7:0]  port_addr;
  logic        pkt_valid;
  logic [7:0]  pkt_da, pkt_sa, pkt_len;
  logic        fcs_err, da_err;
  logic [15:0] pkt_count, err_count;
  logic        busy;

  typedef struct {
    logic [7:0] da;
    logic [7:0] sa;
    logic [7:0] len;
    logic       fe;
    logic       de;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  sw_q[$];
  logic [7:0]  next_byte;
  logic        req_prev;
  int          model_pc = 0;
  int          model_ec = 0;
  int          checks = 0;
  int          fails = 0;

  out_port_receiver dut (
    .clock(clock), .reset(reset), .ready(ready), .data_out(data_out),
    .read(read), .en(en), .port_addr(port_addr), .pkt_valid(pkt_valid),
    .pkt_da(pkt_da), .pkt_sa(pkt_sa), .pkt_len(pkt_len),
    .fcs_err(fcs_err), .da_err(da_err), .pkt_count(pkt_count),
    .err_count(err_count), .busy(busy)
  );

  always #5 clock = ~clock;

  // Queue one packet in the switch model and push its expected result.
  task automatic load_packet(input logic [7:0] da, input logic [7:0] sa,
                             input logic [7:0] len, input logic [7:0] p0,
                             input logic [7:0] p1, input bit bad_fcs,
                             input logic [7:0] fcs_val);
    logic [7:0] x;
    logic [7:0] b;
    logic [7:0] fcs;
    exp_t e;
    sw_q.push_back(da);
    sw_q.push_back(sa);
    sw_q.push_back(len);
    x = da ^ sa ^ len;
    for (int i = 0; i < int'(len); i++) begin
      if (i == 0)      b = p0;
      else if (i == 1) b = p1;
      else             b = 8'(i * 37 + 3);
      sw_q.push_back(b);
      x = x ^ b;
    end
    fcs = bad_fcs ? fcs_val : x;
    sw_q.push_back(fcs);
    e.da  = da;
    e.sa  = sa;
    e.len = len;
    e.fe  = (fcs != x);
    e.de  = (da != port_addr);
    sb.push_back(e);
  endtask

  // Drive the switch side cycle by cycle until the packet completes.
  task automatic run_packet(input int stall_at, input int stall_len,
                            input bit drop_en, input int reset_at);
    int   reads = 0;
    int   stall_left = 0;
    bit   stall_done = 0;
    bit   seen = 0;
    int   exp_reads;
    exp_t e;
    exp_reads = sw_q.size();
    en = 1'b1;
    req_prev = 1'b0;
    for (int cyc = 0; cyc < 600 && !seen; cyc++) begin
      @(negedge clock);
      if (req_prev) data_out = next_byte;
      req_prev = 1'b0;
      if (reset_at >= 0 && reads == reset_at) begin
        reset = 1'b0;
        #1;
        checks++;
        if (read !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_read: got %b expected 0", read); end
        checks++;
        if (busy !== 1'b0 || pkt_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_reset_busy: got busy=%b valid=%b expected 0", busy, pkt_valid); end
        checks++;
        if (pkt_count !== 16'd0 || err_count !== 16'd0 || pkt_len !== 8'd0) begin
          fails++;
          $display("[TB] FAIL mid_reset_clear: got pc=%0d ec=%0d len=%0h expected 0", pkt_count, err_count, pkt_len);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        ready = 1'b0;
        sw_q.delete();
        if (sb.size() > 0) void'(sb.pop_back());
        model_pc = 0;
        model_ec = 0;
        return;
      end
      if (stall_at >= 0 && reads == stall_at && !stall_done && stall_left == 0)
        stall_left = stall_len;
      ready = (sw_q.size() != 0) && (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        checks++;
        if (read !== 1'b0) begin fails++; $display("[TB] FAIL stall_read: got %b expected 0", read); end
        stall_left--;
        if (stall_left == 0) stall_done = 1;
      end
      if (read === 1'b1) begin
        reads++;
        if (sw_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL over_read: got read with empty port after %0d reads", reads);
        end else begin
          next_byte = sw_q.pop_front();
          req_prev = 1'b1;
        end
      end
      if (drop_en && reads == 2) en = 1'b0;
      if (pkt_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_pkt: got pkt_valid expected none");
        end else begin
          e = sb.pop_front();
          if (pkt_da !== e.da || pkt_sa !== e.sa || pkt_len !== e.len) begin
            fails++;
            $display("[TB] FAIL pkt_fields: got %h %h %h expected %h %h %h", pkt_da, pkt_sa, pkt_len, e.da, e.sa, e.len);
          end
          checks++;
          if (fcs_err !== e.fe || da_err !== e.de) begin
            fails++;
            $display("[TB] FAIL pkt_flags: got fcs=%b da=%b expected fcs=%b da=%b", fcs_err, da_err, e.fe, e.de);
          end
          if (model_pc < 65535) model_pc++;
          if ((e.fe || e.de) && model_ec < 65535) model_ec++;
        end
        checks++;
        if (reads != exp_reads) begin fails++; $display("[TB] FAIL read_count: got %0d expected %0d", reads, exp_reads); end
        checks++;
        if (read !== 1'b0) begin fails++; $display("[TB] FAIL done_read: got %b expected 0", read); end
      end
    end
    checks++;
    if (!seen) begin fails++; $display("[TB] FAIL pkt_timeout: got no pkt_valid expected one"); end
    en = 1'b0;
    ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (pkt_count !== 16'(model_pc) || err_count !== 16'(model_ec)) begin
      fails++;
      $display("[TB] FAIL counters: got pc=%0d ec=%0d expected pc=%0d ec=%0d", pkt_count, err_count, model_pc, model_ec);
    end
    checks++;
    if (busy !== 1'b0 || pkt_valid !== 1'b0) begin fails++; $display("[TB] FAIL idle_after: got busy=%b valid=%b expected 0", busy, pkt_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    en = 1'b0;
    ready = 1'b0;
    data_out = 8'h00;
    port_addr = 8'h05;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (read !== 1'b0 || busy !== 1'b0 || pkt_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got read=%b busy=%b valid=%b expected 0", read, busy, pkt_valid);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (pkt_da !== 8'd0 || pkt_sa !== 8'd0 || pkt_len !== 8'd0 || fcs_err !== 1'b0 || da_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_fields: got %h %h %h %b %b expected zeros", pkt_da, pkt_sa, pkt_len, fcs_err, da_err);
    end
    checks++;
    if (pkt_count !== 16'd0 || err_count !== 16'd0 || read !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_counts: got pc=%0d ec=%0d read=%b busy=%b expected 0", pkt_count, err_count, read, busy);
    end
  endtask

  task automatic test_good_packet();
    load_packet(8'h05, 8'h11, 8'h02, 8'hAA, 8'h55, 1'b0, 8'h00);
    run_packet(-1, 0, 1'b0, -1);
  endtask

  task automatic test_bad_packet();
    load_packet(8'h07, 8'h11, 8'h02, 8'hAA, 8'h55, 1'b1, 8'h00);
    run_packet(-1, 0, 1'b0, -1);
    checks++;
    if (pkt_da !== 8'h07 || fcs_err !== 1'b1 || da_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL held_fields: got da=%h fcs=%b da_err=%b expected 07 1 1", pkt_da, fcs_err, da_err);
    end
  endtask

  task automatic test_zero_length();
    load_packet(8'h05, 8'h22, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
    run_packet(-1, 0, 1'b0, -1);
  endtask

  task automatic test_stall();
    load_packet(8'h05, 8'h33, 8'h04, 8'h10, 8'h20, 1'b0, 8'h00);
    run_packet(4, 3, 1'b1, -1);
  endtask

  task automatic test_max_length();
    load_packet(8'h05, 8'h66, 8'hFF, 8'h01, 8'h02, 1'b0, 8'h00);
    run_packet(-1, 0, 1'b0, -1);
  endtask

  task automatic test_mid_reset();
    load_packet(8'h05, 8'h44, 8'h04, 8'h9C, 8'h3E, 1'b0, 8'h00);
    run_packet(-1, 0, 1'b0, 5);
    load_packet(8'h05, 8'h45, 8'h01, 8'h77, 8'h00, 1'b0, 8'h00);
    run_packet(-1, 0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_packet();
    test_zero_length();
    test_stall();
    test_max_length();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
